decode_writeback: RTL and testbench

Decode and write-back stage of the sequential Y86-64 processor: sits directly downstream of fetch, consumes its `icode`/`ifun`/`rA`/`rB` and status flags, and contains the 15-entry, 64-bit program register file. It drives `valA`/`valB` to execute and memory. At each clock edge it commits `valE`/`valM` from execute and memory, and it latches the machine status that stops the processor.

---
 rtl/decode_writeback.sv | 134 +++++++++++++
 tb/tb_decode_writeback.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_writeback.sv
// Y86-64 decode/write-back stage: decode of source/destination registers,
// 15 x 64-bit program register file and the sticky machine status register.
module decode_writeback #(
    parameter logic [3:0] RSP_ID  = 4'h4,
    parameter logic [3:0] NONE_ID = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        Cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        hlt,
    input  logic        imem_err,
    input  logic        instr_err,
    input  logic        dmem_err,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [1:0]  stat,
    output logic        running,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_AOK = 2'b00,
        ST_HLT = 2'b01,
        ST_ADR = 2'b10,
        ST_INS = 2'b11
    } stat_t;

    logic [63:0] regs_q [0:14];
    logic [63:0] regs_d [0:14];
    stat_t       stat_q;
    stat_t       stat_d;
    stat_t       inst_stat;
    logic        wr_en;

    // Decode does not depend on the function code.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    always_comb begin
        srcA = NONE_ID;
        srcB = NONE_ID;
        dstE = NONE_ID;
        dstM = NONE_ID;
        case (icode)
            4'h2: begin
                srcA = rA;
                dstE = Cnd ? rB : NONE_ID;
            end
            4'h3: dstE = rB;
            4'h4: begin
                srcA = rA;
                srcB = rB;
            end
            4'h5: begin
                srcB = rB;
                dstM = rA;
            end
            4'h6: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            4'h8: begin
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            4'h9: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            4'hA: begin
                srcA = rA;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            4'hB: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
                dstM = rA;
            end
            default: ;
        endcase
    end

    assign valA     = (srcA == NONE_ID) ? 64'd0 : regs_q[srcA];
    assign valB     = (srcB == NONE_ID) ? 64'd0 : regs_q[srcB];
    assign dbg_data = (dbg_addr == NONE_ID) ? 64'd0 : regs_q[dbg_addr];

    always_comb begin
        if (imem_err)       inst_stat = ST_ADR;
        else if (instr_err) inst_stat = ST_INS;
        else if (dmem_err)  inst_stat = ST_ADR;
        else if (hlt)       inst_stat = ST_HLT;
        else                inst_stat = ST_AOK;
    end

    assign running = (stat_q == ST_AOK);
    assign stat    = stat_q;
    assign wr_en   = running && (inst_stat == ST_AOK);

    // valM is applied second so it wins when both ports target one register.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            if (dstE != NONE_ID) regs_d[dstE] = valE;
            if (dstM != NONE_ID) regs_d[dstM] = valM;
        end
        stat_d = running ? inst_stat : stat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
            stat_q <= ST_AOK;
        end else begin
            regs_q <= regs_d;
            stat_q <= stat_d;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed scenarios plus random instructions
// compared against a behavioural register-file/status model.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  icode = '0, ifun = '0, rA = 4'hF, rB = 4'hF;
    logic        Cnd = 1'b0;
    logic [63:0] valE = '0, valM = '0;
    logic        hlt = 1'b0, imem_err = 1'b0, instr_err = 1'b0, dmem_err = 1'b0;
    logic [63:0] valA, valB, dbg_data;
    logic [3:0]  srcA, srcB, dstE, dstM, dbg_addr = 4'hF;
    logic [1:0]  stat;
    logic        running;

    decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .Cnd(Cnd), .valE(valE), .valM(valM), .hlt(hlt), .imem_err(imem_err),
        .instr_err(instr_err), .dmem_err(dmem_err), .valA(valA), .valB(valB),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM), .stat(stat),
        .running(running), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] m_regs [15];
    logic [1:0]  m_stat;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_rd(input logic [3:0] idx);
        return (idx == 4'hF) ? 64'd0 : m_regs[idx];
    endfunction

    // Register usage of each instruction class, straight from the ISA table.
    function automatic logic [15:0] m_decode(input logic [3:0] ic, input logic [3:0] a,
                                             input logic [3:0] b, input logic c);
        logic [3:0] sa, sb, de, dm;
        sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? a : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        sb = (ic inside {4'h4, 4'h5, 4'h6}) ? b : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        if (ic == 4'h2)                             de = c ? b : 4'hF;
        else if (ic inside {4'h3, 4'h6})            de = b;
        else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'h4;
        else                                        de = 4'hF;
        dm = (ic inside {4'h5, 4'hB}) ? a : 4'hF;
        return {sa, sb, de, dm};
    endfunction

    function automatic logic [1:0] m_istat();
        if (imem_err)  return 2'b10;
        if (instr_err) return 2'b11;
        if (dmem_err)  return 2'b10;
        if (hlt)       return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_in(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                          input logic [3:0] b, input logic c, input logic [63:0] e,
                          input logic [63:0] m, input logic [3:0] errs);
        icode = ic; ifun = fn; rA = a; rB = b; Cnd = c; valE = e; valM = m;
        {imem_err, instr_err, dmem_err, hlt} = errs;
    endtask

    // Called just after a falling edge with inputs applied; checks, clocks, updates model.
    task automatic step();
        logic [15:0] d;
        logic [1:0]  is;
        dbg_addr = 4'($urandom);
        #1;
        d = m_decode(icode, rA, rB, Cnd);
        check_val("srcA", 64'(srcA), 64'(d[15:12]));
        check_val("srcB", 64'(srcB), 64'(d[11:8]));
        check_val("dstE", 64'(dstE), 64'(d[7:4]));
        check_val("dstM", 64'(dstM), 64'(d[3:0]));
        check_val("valA", valA, m_rd(d[15:12]));
        check_val("valB", valB, m_rd(d[11:8]));
        check_val("dbg_data", dbg_data, m_rd(dbg_addr));
        check_val("stat", 64'(stat), 64'(m_stat));
        check_val("running", 64'(running), 64'(m_stat == 2'b00));
        is = m_istat();
        @(posedge clk);
        if (m_stat == 2'b00) begin
            if (is == 2'b00) begin
                if (d[7:4] != 4'hF) m_regs[d[7:4]] = valE;
                if (d[3:0] != 4'hF) m_regs[d[3:0]] = valM;
            end
            m_stat = is;
        end
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [63:0] exp);
        dbg_addr = a;
        #1;
        check_val(tag, dbg_data, exp);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        m_stat = 2'b00;
        check_val("rst_stat", 64'(stat), 64'd0);
        check_val("rst_running", 64'(running), 64'd1);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        m_stat = 2'b00;
        @(negedge clk);
        set_in(4'h6, 0, 4'h7, 4'h1, 0, 0, 0, 0);
        #1;
        check_val("reset_valA", valA, 64'd0);
        check_val("reset_running", 64'(running), 64'd1);
        check_val("reset_srcA", 64'(srcA), 64'h7);
        rst_n = 1'b1;

        // irmovq
        set_in(4'h3, 0, 4'hF, 4'h2, 0, 64'hFF, 0, 0);
        #1;
        check_val("irm_srcA", 64'(srcA), 64'hF);
        check_val("irm_dstE", 64'(dstE), 64'h2);
        step();
        peek("irm_r2", 4'h2, 64'hFF);

        // opq read/write
        set_in(4'h3, 0, 4'hF, 4'h3, 0, 64'd5, 0, 0); step();
        set_in(4'h3, 0, 4'hF, 4'h4, 0, 64'd5, 0, 0); step();
        set_in(4'h6, 0, 4'h3, 4'h4, 0, 64'd10, 0, 0);
        #1;
        check_val("opq_valA", valA, 64'd5);
        check_val("opq_valB", valB, 64'd5);
        step();
        peek("opq_r4", 4'h4, 64'd10);

        // cmov
        set_in(4'h3, 0, 4'hF, 4'h6, 0, 64'h66, 0, 0); step();
        set_in(4'h2, 4'h5, 4'h5, 4'h6, 0, 64'd7, 0, 0);
        #1;
        check_val("cmov_nt_dstE", 64'(dstE), 64'hF);
        step();
        peek("cmov_nt_r6", 4'h6, 64'h66);
        set_in(4'h2, 4'h5, 4'h5, 4'h6, 1, 64'd7, 0, 0); step();
        peek("cmov_t_r6", 4'h6, 64'd7);
        peek("dbg_F", 4'hF, 64'd0);

        // popq %rsp
        set_in(4'hB, 0, 4'h4, 4'hF, 0, 64'h108, 64'h55, 0);
        #1;
        check_val("pop_dstE", 64'(dstE), 64'h4);
        check_val("pop_dstM", 64'(dstM), 64'h4);
        step();
        peek("pop_r4", 4'h4, 64'h55);

        // halt, then sticky status
        set_in(4'h6, 0, 4'h1, 4'h2, 0, 64'd9, 0, 4'b0001); step();
        check_val("hlt_stat", 64'(stat), 64'h1);
        check_val("hlt_running", 64'(running), 64'd0);
        peek("hlt_r2", 4'h2, 64'hFF);
        set_in(4'h3, 0, 4'hF, 4'h1, 0, 64'hAA, 0, 0); step();
        peek("sticky_r1", 4'h1, 64'd0);

        // status priority from reset
        pulse_reset();
        set_in(4'h3, 0, 4'hF, 4'h1, 0, 64'hAA, 0, 4'b1100); step();
        check_val("prio_stat", 64'(stat), 64'h2);

        // async reset mid-run
        pulse_reset();
        set_in(4'h3, 0, 4'hF, 4'h7, 0, 64'h1234, 0, 0); step();
        peek("r7_set", 4'h7, 64'h1234);
        set_in(4'h0, 0, 4'hF, 4'hF, 0, 0, 0, 4'b0100); step();
        check_val("ins_stat", 64'(stat), 64'h3);
        set_in(4'h6, 0, 4'h7, 4'h7, 0, 0, 0, 0);
        dbg_addr = 4'h7;
        rst_n = 1'b0;
        #1;
        check_val("arst_dbg7", dbg_data, 64'd0);
        check_val("arst_valA", valA, 64'd0);
        pulse_reset();

        // random instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [3:0] errs;
            errs = '0;
            for (int k = 0; k < 4; k++) errs[k] = ($urandom_range(0, 39) == 0);
            set_in(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, errs);
            step();
            if (m_stat != 2'b00 && $urandom_range(0, 3) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
